// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers
module muldiv_seq #(
    parameter logic [4:0] MULT_OP  = 5'b00110,
    parameter logic [4:0] MULTU_OP = 5'b00111,
    parameter logic [4:0] DIV_OP   = 5'b01000,
    parameter logic [4:0] DIVU_OP  = 5'b01001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  alu_ctrl_out,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        divideZero
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t      state_q;
    logic        div_q, neg_q, rneg_q, busy_q, done_q, dz_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    logic [63:0] acc_q;
    logic [4:0]  cnt_q;
    logic        legal_op, is_div, is_sgn, fits;
    logic [31:0] abs1, abs2, quo, rem;
    logic [32:0] trial;
    logic [63:0] acc_d, prod;
    assign legal_op = (alu_ctrl_out == MULT_OP) | (alu_ctrl_out == MULTU_OP) |
                      (alu_ctrl_out == DIV_OP)  | (alu_ctrl_out == DIVU_OP);
    assign is_div   = (alu_ctrl_out == DIV_OP) | (alu_ctrl_out == DIVU_OP);
    assign is_sgn   = (alu_ctrl_out == MULT_OP) | (alu_ctrl_out == DIV_OP);
    assign abs1     = (is_sgn && op1[31]) ? -op1 : op1;
    assign abs2     = (is_sgn && op2[31]) ? -op2 : op2;
    // Restoring step: partial remainder shifted left with the next dividend bit
    assign trial    = acc_q[63:31];
    assign fits     = trial >= {1'b0, a_q};
    assign acc_d    = div_q ? {fits ? trial[31:0] - a_q : trial[31:0], acc_q[30:0], fits}
                            : acc_q + (b_q[cnt_q] ? {32'b0, a_q} << cnt_q : 64'b0);
    assign prod     = neg_q ? -acc_q : acc_q;
    assign quo      = neg_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem      = rneg_q ? -acc_q[63:32] : acc_q[63:32];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start && legal_op && !flush) begin
                        if (is_div && op2 == '0) dz_q <= 1'b1;
                        else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            div_q   <= is_div;
                            neg_q   <= is_sgn & (op1[31] ^ op2[31]);
                            rneg_q  <= is_sgn & op1[31];
                            a_q     <= is_div ? abs2 : abs1;
                            b_q     <= abs2;
                            acc_q   <= is_div ? {32'b0, abs1} : 64'b0;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!flush) begin
                        hi_q   <= div_q ? rem : prod[63:32];
                        lo_q   <= div_q ? quo : prod[31:0];
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign divideZero = dz_q;
    assign stall      = busy_q | (start & legal_op & (state_q == IDLE));
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven and directed checks of the muldiv_seq sequencer
module tb_muldiv_seq;
    localparam logic [4:0] MULT  = 5'b00110;
    localparam logic [4:0] MULTU = 5'b00111;
    localparam logic [4:0] DIV   = 5'b01000;
    localparam logic [4:0] DIVU  = 5'b01001;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [4:0]  alu_ctrl_out = '0;
    logic [31:0] op1 = '0, op2 = '0, wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, stall, done, divideZero;
    int          checks = 0, errors = 0;
    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t vecs[12];
    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl_out(alu_ctrl_out),
        .op1(op1), .op2(op2), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .stall(stall),
        .done(done), .divideZero(divideZero)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask
    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int bc, output logic d_end, output logic dz1, output logic d1);
        alu_ctrl_out = op;
        op1 = a;
        op2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dz1 = divideZero;
        d1 = done;
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        d_end = done;
    endtask
    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask
    int   bc;
    logic d_end, dz1, d1, seen;
    initial begin
        vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        vecs[6]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[8]  = '{DIVU,  32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF};
        vecs[9]  = '{DIVU,  32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001};
        vecs[10] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[11] = '{DIVU,  32'd5,        32'h80000000, 32'd5,        32'd0};
        wait_cycles(2);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_dz", 32'(divideZero), 0);
        rst_n = 1'b1;
        wait_cycles(1);
        // Back-to-back: each new start lands in the done cycle of the previous op
        foreach (vecs[i]) begin
            run(vecs[i].op, vecs[i].a, vecs[i].b, bc, d_end, dz1, d1);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 33);
            chk($sformatf("v%0d_done", i), 32'(d_end), 1);
            chk($sformatf("v%0d_dz", i), 32'(dz1), 0);
            chk($sformatf("v%0d_prev_done_width", i), 32'(d1), 0);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
        end
        wait_cycles(1);
        chk("done_single_pulse", 32'(done), 0);
        // MTHI/MTLO then divide by zero
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'h5678);
        alu_ctrl_out = DIV; op1 = 32'd9; op2 = 32'd0; start = 1'b1;
        #1 chk("dz_stall", 32'(stall), 1);
        @(negedge clk);
        start = 1'b0;
        chk("dz_pulse", 32'(divideZero), 1);
        chk("dz_no_done", 32'(done), 0);
        chk("dz_no_busy", 32'(busy), 0);
        @(negedge clk);
        chk("dz_pulse_end", 32'(divideZero), 0);
        chk("dz_busy_later", 32'(busy), 0);
        chk("dz_hi_kept", hi, 32'h1234);
        chk("dz_lo_kept", lo, 32'h5678);
        // Illegal op code is ignored
        alu_ctrl_out = 5'b00000; start = 1'b1;
        #1 chk("illegal_stall", 32'(stall), 0);
        @(negedge clk);
        start = 1'b0;
        chk("illegal_busy", 32'(busy), 0);
        // Flush mid-CALC
        alu_ctrl_out = MULTU; op1 = 32'd3; op2 = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cycles(9);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", 32'(busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= done | busy;
        end
        chk("flush_no_done", 32'(seen), 0);
        chk("flush_hi_kept", hi, 32'h1234);
        chk("flush_lo_kept", lo, 32'h5678);
        run(MULTU, 32'd3, 32'd5, bc, d_end, dz1, d1);
        chk("restart_done", 32'(d_end), 1);
        chk("restart_hi", hi, 0);
        chk("restart_lo", lo, 15);
        // Flush during FIX beats the writeback
        alu_ctrl_out = MULTU; op1 = 32'd2; op2 = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cycles(32);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fixflush_done", 32'(done), 0);
        chk("fixflush_busy", 32'(busy), 0);
        chk("fixflush_lo", lo, 15);
        // start and hi_we while busy are ignored
        alu_ctrl_out = DIVU; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(negedge clk);
        alu_ctrl_out = DIV; op2 = 32'd0; hi_we = 1'b1; wdata = 32'hDEAD;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen |= divideZero;
        end
        chk("busy_stall", 32'(stall), 1);
        start = 1'b0; hi_we = 1'b0;
        chk("busy_start_ignored", 32'(seen), 0);
        chk("busy_hiwe_ignored", hi, 0);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        chk("busy_result_done", 32'(done), 1);
        chk("busy_result_hi", hi, 2);
        chk("busy_result_lo", lo, 14);
        // Asynchronous reset mid-CALC
        alu_ctrl_out = MULTU; op1 = 32'd9; op2 = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cycles(5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);
        chk("rst_stays_idle", 32'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
